// File: rtl/booth4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, WIDTH/2+1 digit cycles,
// per-operation signed/unsigned mode, valid/ready handshake on both sides.
module booth4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int EW = WIDTH + 2;
    localparam int AW = WIDTH + 4;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [EW-1:0]  a_q, a_d;
    logic signed [AW-1:0]  hi_q, hi_d;
    logic [EW-1:0]         lo_q, lo_d;
    logic                  prev_q, prev_d;
    logic [2*WIDTH-1:0]    prod_q, prod_d;

    logic                  accept;
    logic signed [AW-1:0]  a_wide;
    logic signed [AW-1:0]  pp;
    logic signed [AW-1:0]  sum;

    function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
        return {{2{sgn & v[WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] trip,
                                                      input logic signed [AW-1:0] m);
        case (trip)
            3'b001, 3'b010: return m;
            3'b011:         return m <<< 1;
            3'b100:         return -(m <<< 1);
            3'b101, 3'b110: return -m;
            default:        return '0;
        endcase
    endfunction

    // in_ready is forced low while reset is held so nothing is accepted during reset
    assign in_ready  = rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign product   = prod_q;

    // Two guard bits on hi_q keep |hi + 2*a_ext| in range for both modes
    assign a_wide = {{(AW-EW){a_q[EW-1]}}, a_q};
    assign pp     = booth_pp({lo_q[1:0], prev_q}, a_wide);
    assign sum    = hi_q + pp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prev_d  = prev_q;
        prod_d  = prod_q;
        if (accept) begin
            state_d = CALC;
            cnt_d   = '0;
            a_d     = extend(a, is_signed);
            lo_d    = extend(b, is_signed);
            hi_d    = '0;
            prev_d  = 1'b0;
        end else begin
            case (state_q)
                CALC: begin
                    // {hi, lo} shifts right two places; consumed multiplier bits leave lo
                    hi_d   = sum >>> 2;
                    lo_d   = {sum[1:0], lo_q[EW-1:2]};
                    prev_d = lo_q[1];
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        prod_d  = {hi_d[WIDTH-3:0], lo_d};
                    end
                end
                DONE:    if (out_ready) state_d = IDLE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prev_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prev_q  <= prev_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Directed bench for booth4_seq_mult: 8-bit and 16-bit instances, hand-computed products.
module tb_booth4_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          fails  = 0;

    logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic        in_valid16, in_ready16, is_signed16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    logic [7:0]  sa [3] = '{8'h80, 8'h80, 8'hFF};
    logic [7:0]  sb [3] = '{8'h80, 8'h7F, 8'h01};
    logic [15:0] se [3] = '{16'h4000, 16'hC080, 16'hFFFF};

    logic [7:0]  ba [3] = '{8'd200, 8'hFB, 8'd16};
    logic [7:0]  bb [3] = '{8'd3, 8'd6, 8'd16};
    logic        bs [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] be [3] = '{16'h0258, 16'hFFE2, 16'h0100};

    always #5 clk = ~clk;

    booth4_seq_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8)
    );

    booth4_seq_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .is_signed(is_signed16), .out_valid(out_valid16),
        .out_ready(out_ready16), .product(product16)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic s);
        a8 = x; b8 = y; is_signed8 = s; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait8(output int cyc);
        cyc = 0;
        while (!out_valid8 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic issue16(input logic [15:0] x, input logic [15:0] y, input logic s);
        a16 = x; b16 = y; is_signed16 = s; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic wait16(output int cyc);
        cyc = 0;
        while (!out_valid16 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if (in_ready8 !== 1'b0) begin fails++; $display("FAIL reset_in_ready8: got %b want 0", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin fails++; $display("FAIL reset_out_valid8: got %b want 0", out_valid8); end
        checks++; if (product8 !== 16'h0) begin fails++; $display("FAIL reset_product8: got %h want 0000", product8); end
        checks++; if (in_ready16 !== 1'b0) begin fails++; $display("FAIL reset_in_ready16: got %b want 0", in_ready16); end
        checks++; if (out_valid16 !== 1'b0) begin fails++; $display("FAIL reset_out_valid16: got %b want 0", out_valid16); end
        checks++; if (product16 !== 32'h0) begin fails++; $display("FAIL reset_product16: got %h want 00000000", product16); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (in_ready8 !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready8: got %b want 1", in_ready8); end
    endtask

    task automatic test_unsigned_max;
        int cyc;
        issue8(8'd255, 8'd255, 1'b0);
        wait8(cyc);
        checks++; if (cyc !== 5) begin fails++; $display("FAIL umax_latency: got %0d want 5", cyc); end
        checks++; if (product8 !== 16'hFE01) begin fails++; $display("FAIL umax_product: got %h want fe01", product8); end
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b0) begin fails++; $display("FAIL umax_drain: got %b want 0", out_valid8); end
        checks++; if (product8 !== 16'hFE01) begin fails++; $display("FAIL umax_hold: got %h want fe01", product8); end
    endtask

    task automatic test_signed_corners;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            issue8(sa[i], sb[i], 1'b1);
            wait8(cyc);
            checks++; if (cyc !== 5) begin fails++; $display("FAIL signed_latency[%0d]: got %0d want 5", i, cyc); end
            checks++; if (product8 !== se[i]) begin fails++; $display("FAIL signed_product[%0d]: got %h want %h", i, product8, se[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        out_ready8 = 1'b0;
        issue8(8'd12, 8'd13, 1'b0);
        wait8(cyc);
        checks++; if (product8 !== 16'h009C) begin fails++; $display("FAIL bp_product: got %h want 009c", product8); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid8 !== 1'b1) begin fails++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid8); end
            checks++; if (product8 !== 16'h009C) begin fails++; $display("FAIL bp_hold_product[%0d]: got %h want 009c", i, product8); end
            checks++; if (in_ready8 !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", i, in_ready8); end
        end
        a8 = 8'd7; b8 = 8'hFD; is_signed8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
        #1;
        checks++; if (in_ready8 !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready8); end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        checks++; if (out_valid8 !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", out_valid8); end
        wait8(cyc);
        checks++; if (cyc !== 5) begin fails++; $display("FAIL bp_next_latency: got %0d want 5", cyc); end
        checks++; if (product8 !== 16'hFFEB) begin fails++; $display("FAIL bp_next_product: got %h want ffeb", product8); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int  idx = 0;
        int  nres = 0;
        int  last = 0;
        logic acc;
        a8 = ba[0]; b8 = bb[0]; is_signed8 = bs[0]; in_valid8 = 1'b1; out_ready8 = 1'b1;
        for (int c = 0; c < 40 && nres < 3; c++) begin
            acc = in_valid8 & in_ready8;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    a8 = ba[idx]; b8 = bb[idx]; is_signed8 = bs[idx];
                end else begin
                    in_valid8 = 1'b0;
                end
            end
            if (out_valid8) begin
                checks++; if (product8 !== be[nres]) begin fails++; $display("FAIL b2b_product[%0d]: got %h want %h", nres, product8, be[nres]); end
                if (nres > 0) begin
                    checks++; if (c - last !== 6) begin fails++; $display("FAIL b2b_interval[%0d]: got %0d want 6", nres, c - last); end
                end
                last = c;
                nres++;
            end
        end
        in_valid8 = 1'b0;
        checks++; if (nres !== 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", nres); end
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", out_valid8); end
    endtask

    task automatic test_reset_mid_op;
        int   cyc;
        logic seen = 1'b0;
        issue8(8'd100, 8'd100, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (out_valid8 !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", out_valid8); end
        checks++; if (product8 !== 16'h0) begin fails++; $display("FAIL rst_mid_product: got %h want 0000", product8); end
        checks++; if (in_ready8 !== 1'b0) begin fails++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready8); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid8) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_mid_no_valid: got %b want 0", seen); end
        issue8(8'd0, 8'd200, 1'b0);
        wait8(cyc);
        checks++; if (cyc !== 5) begin fails++; $display("FAIL rst_next_latency: got %0d want 5", cyc); end
        checks++; if (product8 !== 16'h0000) begin fails++; $display("FAIL rst_next_product: got %h want 0000", product8); end
        @(posedge clk); #1;
    endtask

    task automatic test_width16;
        int cyc;
        issue16(16'h8000, 16'hFFFF, 1'b1);
        wait16(cyc);
        checks++; if (cyc !== 9) begin fails++; $display("FAIL w16_signed_latency: got %0d want 9", cyc); end
        checks++; if (product16 !== 32'h0000_8000) begin fails++; $display("FAIL w16_signed_product: got %h want 00008000", product16); end
        @(posedge clk); #1;
        issue16(16'hFFFF, 16'h0002, 1'b0);
        wait16(cyc);
        checks++; if (cyc !== 9) begin fails++; $display("FAIL w16_unsigned_latency: got %0d want 9", cyc); end
        checks++; if (product16 !== 32'h0001_FFFE) begin fails++; $display("FAIL w16_unsigned_product: got %h want 0001fffe", product16); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; is_signed8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; is_signed16 = 1'b0; out_ready16 = 1'b1;
        test_reset;
        test_unsigned_max;
        test_signed_corners;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_op;
        test_width16;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
